// File: rtl/screen_router.sv
// Screen state machine for the race game: MENU / READY / RACING / FINISHED.
// Per-player finish/move detection feeds a lowest-index winner select and a hold timer.

module screen_router_lane #(
    parameter int POS_WIDTH = 7,
    parameter int MAX_POS   = 109
) (
    input  logic [POS_WIDTH-1:0] pos,
    output logic                 finished,
    output logic                 moved
);
    // Values beyond the finish line still count as finished.
    assign finished = (pos >= POS_WIDTH'(MAX_POS));
    assign moved    = (pos != '0);
endmodule

module screen_router #(
    parameter  int NUM_PLAYERS = 4,
    parameter  int POS_WIDTH   = 7,
    parameter  int MAX_POS     = 109,
    parameter  int HOLD_CYCLES = 25_000_000,
    localparam int ID_WIDTH    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PLAYERS*POS_WIDTH-1:0] cur_pos,
    input  logic                           is_in_menu,
    output logic [1:0]                     current_screen,
    output logic [ID_WIDTH-1:0]            winner_id,
    output logic                           winner_valid,
    output logic                           screen_changed,
    output logic                           hold_done
);
    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(HOLD_CYCLES);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_MENU     = 2'b00,
        S_RACING   = 2'b01,
        S_FINISHED = 2'b10,
        S_READY    = 2'b11
    } screen_t;

    screen_t state, nxt;
    logic [HC_W-1:0] hold_cnt;

    logic [NUM_PLAYERS-1:0][POS_WIDTH-1:0] pos_arr;
    logic [NUM_PLAYERS-1:0]                fin_vec;
    logic [NUM_PLAYERS-1:0]                mov_vec;
    logic                                  any_finished;
    logic                                  any_moved;
    logic [ID_WIDTH-1:0]                   first_fin;

    assign pos_arr = cur_pos;

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g++) begin : g_lane
            screen_router_lane #(
                .POS_WIDTH (POS_WIDTH),
                .MAX_POS   (MAX_POS)
            ) u_lane (
                .pos      (pos_arr[g]),
                .finished (fin_vec[g]),
                .moved    (mov_vec[g])
            );
        end
    endgenerate

    assign any_finished = |fin_vec;
    assign any_moved    = |mov_vec;

    // Scan high to low so the lowest finishing index wins ties.
    always_comb begin
        first_fin = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (fin_vec[i]) first_fin = ID_WIDTH'(i);
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_MENU: begin
                if (!is_in_menu) nxt = S_READY;
            end
            S_READY: begin
                if (is_in_menu)        nxt = S_MENU;
                else if (any_finished) nxt = S_FINISHED;
                else if (any_moved)    nxt = S_RACING;
            end
            S_RACING: begin
                if (is_in_menu)        nxt = S_MENU;
                else if (any_finished) nxt = S_FINISHED;
            end
            S_FINISHED: begin
                // Menu requests before the hold expires are dropped, not remembered.
                if (hold_done && is_in_menu) nxt = S_MENU;
            end
            default: nxt = S_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_MENU;
            winner_id      <= '0;
            winner_valid   <= 1'b0;
            screen_changed <= 1'b0;
            hold_done      <= 1'b0;
            hold_cnt       <= '0;
        end else begin
            state          <= nxt;
            screen_changed <= (nxt != state);
            winner_valid   <= (nxt == S_FINISHED);
            if (nxt == S_FINISHED) begin
                if (state != S_FINISHED) begin
                    winner_id <= first_fin;
                    hold_cnt  <= '0;
                    hold_done <= 1'b0;
                end else begin
                    if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
                    hold_done <= (hold_cnt >= HOLD_LAST);
                end
            end else begin
                hold_cnt  <= '0;
                hold_done <= 1'b0;
                if (nxt == S_MENU) winner_id <= '0;
            end
        end
    end

    assign current_screen = state;

endmodule

// File: tb/tb_screen_router.sv
// Randomised plus directed bench for screen_router; two configurations share one clock,
// a screen-level reference model fills a scoreboard that a separate monitor drains.

module tb_screen_router;
    localparam int N1 = 4, W1 = 7, MAX1 = 109, HOLD1 = 8;
    localparam int N2 = 2, W2 = 5, MAX2 = 20,  HOLD2 = 3;
    localparam int MENU = 0, RACING = 1, FIN = 2, READY = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset1, menu_in1, reset2, menu_in2;
    logic [N1*W1-1:0] cp1;
    logic [N2*W2-1:0] cp2;
    logic [1:0] scr1, scr2;
    logic [1:0] wid1;
    logic [0:0] wid2;
    logic wv1, chg1, hd1, wv2, chg2, hd2;

    screen_router #(.NUM_PLAYERS(N1), .POS_WIDTH(W1), .MAX_POS(MAX1), .HOLD_CYCLES(HOLD1)) dut (
        .clk(clk), .reset(reset1), .cur_pos(cp1), .is_in_menu(menu_in1),
        .current_screen(scr1), .winner_id(wid1), .winner_valid(wv1),
        .screen_changed(chg1), .hold_done(hd1));

    screen_router #(.NUM_PLAYERS(N2), .POS_WIDTH(W2), .MAX_POS(MAX2), .HOLD_CYCLES(HOLD2)) dut2 (
        .clk(clk), .reset(reset2), .cur_pos(cp2), .is_in_menu(menu_in2),
        .current_screen(scr2), .winner_id(wid2), .winner_valid(wv2),
        .screen_changed(chg2), .hold_done(hd2));

    typedef struct {
        int scr;
        int wid;
        int wv;
        int chg;
        int hd;
        int elapsed;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    exp_t sbq[$];
    int nvec = 0;
    int nerr = 0;

    int p1[4];
    int p2[4];
    bit r1, m1, r2, m2;
    mdl_t s1, s2;

    // Screen-level behaviour: what the display should show after this clock edge.
    function automatic mdl_t mstep(mdl_t m, bit rst, bit menu, int p[4], int np, int maxp, int hold);
        mdl_t r;
        int win = -1;
        bit moved = 0;
        int nx;
        for (int i = 0; i < np; i++) begin
            if (p[i] >= maxp && win < 0) win = i;
            if (p[i] != 0) moved = 1;
        end
        r.scr = MENU; r.wid = 0; r.wv = 0; r.chg = 0; r.hd = 0; r.elapsed = 0;
        if (rst) return r;
        nx = m.scr;
        if (m.scr == MENU) begin
            if (!menu) nx = READY;
        end else if (m.scr == READY) begin
            if (menu) nx = MENU;
            else if (win >= 0) nx = FIN;
            else if (moved) nx = RACING;
        end else if (m.scr == RACING) begin
            if (menu) nx = MENU;
            else if (win >= 0) nx = FIN;
        end else begin
            if (m.hd != 0 && menu) nx = MENU;
        end
        r.scr = nx;
        r.chg = (nx != m.scr);
        r.wv  = (nx == FIN);
        if (nx == FIN && m.scr != FIN) begin
            r.wid = win;
            r.elapsed = 0;
        end else if (nx == FIN) begin
            r.wid = m.wid;
            r.elapsed = (m.elapsed + 1 > hold) ? hold : m.elapsed + 1;
        end else begin
            r.wid = (nx == MENU) ? 0 : m.wid;
        end
        r.hd = (nx == FIN && r.elapsed >= hold);
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        reset1 = r1; menu_in1 = m1;
        reset2 = r2; menu_in2 = m2;
        for (int i = 0; i < N1; i++) cp1[i*W1 +: W1] = W1'(p1[i]);
        for (int i = 0; i < N2; i++) cp2[i*W2 +: W2] = W2'(p2[i]);
        s1 = mstep(s1, r1, m1, p1, N1, MAX1, HOLD1);
        s2 = mstep(s2, r2, m2, p2, N2, MAX2, HOLD2);
        e.a = s1;
        e.b = s2;
        sbq.push_back(e);
    endtask

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr1();
        for (int i = 0; i < 4; i++) p1[i] = 0;
    endtask

    task automatic clr2();
        for (int i = 0; i < 4; i++) p2[i] = 0;
    endtask

    // Monitor: outputs are presented every cycle, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("scr1", int'(scr1), e.a.scr);
                chk("wid1", int'(wid1), e.a.wid);
                chk("wv1",  int'(wv1),  e.a.wv);
                chk("chg1", int'(chg1), e.a.chg);
                chk("hd1",  int'(hd1),  e.a.hd);
                chk("scr2", int'(scr2), e.b.scr);
                chk("wid2", int'(wid2), e.b.wid);
                chk("wv2",  int'(wv2),  e.b.wv);
                chk("chg2", int'(chg2), e.b.chg);
                chk("hd2",  int'(hd2),  e.b.hd);
            end
        end
    end

    initial begin
        reset1 = 1'b1; menu_in1 = 1'b1; cp1 = '0;
        reset2 = 1'b1; menu_in2 = 1'b1; cp2 = '0;
        s1 = '{default: 0};
        s2 = '{default: 0};
        clr1(); clr2();
        r1 = 1; m1 = 1; r2 = 1; m2 = 1;
        tick(); tick();

        // Out of reset into READY, single change pulse.
        r1 = 0; m1 = 0; r2 = 0; m2 = 0;
        tick(); tick();

        // READY -> RACING -> FINISHED with red; small config finishes on an out-of-range 31.
        p1[1] = 1; tick();
        p1[1] = 109; p2[1] = 31; tick();

        // Menu held through the hold window; exit only after hold_done.
        m1 = 1;
        repeat (10) tick();
        m1 = 0; clr1(); tick();

        // Simultaneous green/blue finish resolves to green.
        p1[0] = 5; tick();
        p1[0] = 109; p1[2] = 109; tick();
        m1 = 1;
        repeat (10) tick();
        m1 = 0; clr1(); tick();

        // Menu beats a same-cycle finish in RACING.
        p1[3] = 3; tick();
        m1 = 1; p1[3] = 109; tick();
        m1 = 0; clr1(); tick();

        // Reset in the middle of the hold.
        p1[2] = 120; tick();
        repeat (4) tick();
        r1 = 1; r2 = 1; tick();
        r1 = 0; r2 = 0; clr2(); tick(); tick();

        for (int c = 0; c < 500; c++) begin
            r1 = ($urandom_range(0, 59) == 0);
            r2 = ($urandom_range(0, 59) == 0);
            m1 = ($urandom_range(0, 3) == 0);
            m2 = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                p1[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : 0;
                p2[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 0;
            end
            tick();
        end

        repeat (3) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
